// File: rtl/aes_enc_iter_umsk.sv
// Iterative unmasked AES-128 encryptor: one shared round, ten cycles per block.
// Valid/ready handshakes on both the plaintext/key input and the ciphertext output.

module aes_round_umsk (
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] state_out,
    output logic [127:0] key_out
);

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box computed as b^254 (field inverse, 0 -> 0) then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        logic [7:0] s;
        r = 8'h01;
        p = b;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
              ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {b3, b2, b1, b0};
    endfunction

    logic [127:0] ark;
    logic [127:0] sb;
    logic [127:0] sr;
    logic [31:0]  w3;
    logic [31:0]  rot;
    logic [31:0]  tmp;
    logic [31:0]  k0, k1, k2, k3;

    always_comb begin
        ark = state_in ^ key_in;
        sb  = '0;
        sr  = '0;
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[8*i +: 8] = sbox(ark[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            state_out[32*c +: 32] = mix_col(sr[32*c +: 32]);
        end
    end

    always_comb begin
        w3  = key_in[127:96];
        rot = {w3[7:0], w3[31:8]};
        tmp = '0;
        for (int i = 0; i < 4; i++) begin
            tmp[8*i +: 8] = sbox(rot[8*i +: 8]);
        end
        tmp = tmp ^ {24'h0, rcon};
        k0  = key_in[31:0] ^ tmp;
        k1  = key_in[63:32] ^ k0;
        k2  = key_in[95:64] ^ k1;
        k3  = key_in[127:96] ^ k2;
        key_out = {k3, k2, k1, k0};
    end

endmodule

module aes_enc_iter_umsk #(
    parameter bit CLEAR_ON_POP = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [7:0]   rcon;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] state_out;
    logic [127:0] key_out;
    logic [127:0] ct_next;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m09 [4];
        logic [7:0] m0b [4];
        logic [7:0] m0d [4];
        logic [7:0] m0e [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[8*i +: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m09[i] = x8 ^ a[i];
            m0b[i] = x8 ^ x2 ^ a[i];
            m0d[i] = x8 ^ x4 ^ a[i];
            m0e[i] = x8 ^ x4 ^ x2;
        end
        return {m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3],
                m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
                m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
                m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3]};
    endfunction

    aes_round_umsk u_round (
        .state_in  (state_reg),
        .key_in    (key_reg),
        .rcon      (rcon),
        .state_out (state_out),
        .key_out   (key_out)
    );

    // Last round: undo the MixColumns the shared round always applies
    always_comb begin
        ct_next = '0;
        for (int c = 0; c < 4; c++) begin
            ct_next[32*c +: 32] = inv_mix_col(state_out[32*c +: 32]);
        end
        ct_next = ct_next ^ key_out;
    end

    assign in_ready = (fsm == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ciphertext <= '0;
            cnt        <= '0;
            rcon       <= 8'h01;
            state_reg  <= '0;
            key_reg    <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext;
                        key_reg   <= key;
                        rcon      <= 8'h01;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == 4'd9) begin
                        ciphertext <= ct_next;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                        fsm        <= DONE;
                    end else begin
                        state_reg <= state_out;
                        key_reg   <= key_out;
                        rcon      <= xt(rcon);
                        cnt       <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= IDLE;
                        if (CLEAR_ON_POP) ciphertext <= '0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter_umsk.sv
// Directed bench for aes_enc_iter_umsk: FIPS-197 vectors plus
// backpressure, back-to-back, abort and ignore-while-busy sequences.

module tb_aes_enc_iter_umsk;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;

    int checks;
    int failures;

    typedef struct {
        logic [127:0] k;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
    } vec_t;

    vec_t vecs [2];

    aes_enc_iter_umsk dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic accept(input logic [127:0] kk, input logic [127:0] pp);
        @(negedge clk);
        chk("in_ready_idle", 128'(in_ready), 128'(1));
        key       = kk;
        plaintext = pp;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", 128'(busy), 128'(1));
        chk("in_ready_in_run", 128'(in_ready), 128'(0));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_pop", 128'(out_valid), 128'(0));
        chk("in_ready_after_pop", 128'(in_ready), 128'(1));
    endtask

    initial begin
        int lat;
        logic [127:0] held;

        checks    = 0;
        failures  = 0;
        vecs[0]   = '{128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b,
                      128'h340737e0_a2983131_8d305a88_a8f64332,
                      128'h320b6a19_978511dc_fb09dc02_1d842539, 10};
        vecs[1]   = '{128'h0f0e0d0c_0b0a0908_07060504_03020100,
                      128'hffeeddcc_bbaa9988_77665544_33221100,
                      128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469, 10};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ciphertext", ciphertext, 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // T1/T2 from the table, immediate pop
        for (int i = 0; i < 2; i++) begin
            accept(vecs[i].k, vecs[i].pt);
            wait_out(lat);
            chk("latency", 128'(lat), 128'(vecs[i].lat));
            chk("ciphertext", ciphertext, vecs[i].ct);
            pop();
            chk("ct_held_after_pop", ciphertext, vecs[i].ct);
        end

        // T3 backpressure
        accept(vecs[0].k, vecs[0].pt);
        wait_out(lat);
        chk("bp_latency", 128'(lat), 128'(10));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_ciphertext", ciphertext, vecs[0].ct);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        pop();

        // T4 back-to-back with in_valid and out_ready held high
        @(negedge clk);
        key       = vecs[0].k;
        plaintext = vecs[0].pt;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_first_accept", 128'(busy), 128'(1));
        key       = vecs[1].k;
        plaintext = vecs[1].pt;
        wait_out(lat);
        chk("b2b_latency1", 128'(lat), 128'(10));
        chk("b2b_ct1", ciphertext, vecs[0].ct);
        @(posedge clk);
        #1;
        chk("b2b_popped", 128'(out_valid), 128'(0));
        chk("b2b_idle_gap", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_second_accept", 128'(busy), 128'(1));
        chk("b2b_in_ready_run", 128'(in_ready), 128'(0));
        wait_out(lat);
        chk("b2b_latency2", 128'(lat), 128'(10));
        chk("b2b_ct2", ciphertext, vecs[1].ct);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("b2b_popped2", 128'(out_valid), 128'(0));

        // T5 abort at cnt=5
        accept(vecs[0].k, vecs[0].pt);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_ciphertext", ciphertext, 128'h0);
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_result", 128'(out_valid), 128'(0));
        end
        accept(vecs[1].k, vecs[1].pt);
        wait_out(lat);
        chk("abort_next_latency", 128'(lat), 128'(10));
        chk("abort_next_ct", ciphertext, vecs[1].ct);
        pop();

        // T6 input changes and in_valid pulses while busy are ignored
        accept(vecs[0].k, vecs[0].pt);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            key       = {$urandom, $urandom, $urandom, $urandom};
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = (i % 2 == 0);
        end
        in_valid = 1'b0;
        wait_out(lat);
        chk("ignore_latency", 128'(lat), 128'(7));
        chk("ignore_ct", ciphertext, vecs[0].ct);
        held = ciphertext;
        pop();
        chk("ignore_ct_held", ciphertext, held);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
